operand_fetch_stage: RTL and testbench

- Decode/operand-fetch stage sitting directly upstream of the 4x16 register file.
- Accepts 8-bit instruction bytes from fetch, drives the register-file read indices, and captures the returned operands into an ID/EX pipeline register for the execute stage.
- Tracks in-flight destination writes with a 4-entry scoreboard and stalls on RAW/WAW hazards.
- Assembles the two-byte LDI instruction with a small state machine.

---
 rtl/operand_fetch_stage.sv | 201 ++++++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: decodes instruction bytes, reads the 4x16 register file, tracks
// in-flight destinations on a 4-entry scoreboard and assembles the two-byte LDI instruction.
module operand_fetch_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter logic [3:0]  OPC_LDI = 4'h7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_instr,
  output logic [1:0]        rd_index1,
  output logic [1:0]        rd_index2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              wb_valid,
  input  logic [1:0]        wb_index,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [1:0]        out_dst,
  output logic              out_wr,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  typedef enum logic [0:0] {StInstr, StImm} state_e;

  state_e state_q, state_d;

  logic [3:0]        pend_q, pend_d;
  logic [3:0]        pend_set, pend_clr;
  logic [1:0]        ldi_dst_q, ldi_dst_d;

  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_opcode_q, out_opcode_d;
  logic [1:0]        out_dst_q, out_dst_d;
  logic              out_wr_q, out_wr_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;

  logic [3:0] opcode;
  logic [1:0] ra, rb;
  logic       uses_a, uses_b, writes, is_ldi;
  logic       slot_free, hazard, accept;
  logic       ldi_first, load_out;

  assign opcode    = in_instr[7:4];
  assign ra        = in_instr[3:2];
  assign rb        = in_instr[1:0];
  assign rd_index1 = ra;
  assign rd_index2 = rb;

  // Operand/destination usage per opcode class.
  always_comb begin
    uses_a = 1'b0;
    uses_b = 1'b0;
    writes = 1'b0;
    is_ldi = (opcode == OPC_LDI);
    case (opcode)
      4'h1, 4'h2, 4'h5: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        writes = 1'b1;
      end
      4'h3, 4'h4: begin
        uses_a = 1'b1;
        writes = 1'b1;
      end
      4'h6: begin
        uses_b = 1'b1;
        writes = 1'b1;
      end
      4'h8: uses_a = 1'b1;
      default: ;
    endcase
    if (is_ldi) begin
      uses_a = 1'b0;
      uses_b = 1'b0;
      writes = 1'b1;
    end
  end

  // Hazards look only at registered pend bits; a same-cycle writeback does not bypass.
  assign hazard    = (uses_a && pend_q[ra]) || (uses_b && pend_q[rb]) || (writes && pend_q[ra]);
  assign slot_free = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign ldi_first = accept && (state_q == StInstr) && is_ldi;
  assign load_out  = accept && !ldi_first;

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInstr;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StInstr;
    end else if (accept) begin
      state_d = ldi_first ? StImm : StInstr;
    end
  end

  // FSM: outputs.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !flush && slot_free) begin
      unique case (state_q)
        StInstr: in_ready = !hazard;
        StImm:   in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: clears from writeback and flush, set takes precedence on the same index.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (wb_valid) pend_clr[wb_index] = 1'b1;
    if (flush) begin
      if (out_valid_q && out_wr_q && !out_ready) pend_clr[out_dst_q] = 1'b1;
      if (state_q == StImm) pend_clr[ldi_dst_q] = 1'b1;
    end else if (accept && (state_q == StInstr) && writes) begin
      pend_set[ra] = 1'b1;
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_comb begin
    ldi_dst_d = ldi_dst_q;
    if (ldi_first) ldi_dst_d = ra;
  end

  // ID/EX register next state.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_dst_d    = out_dst_q;
    out_wr_d     = out_wr_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_out) begin
      out_valid_d = 1'b1;
      if (state_q == StImm) begin
        out_opcode_d = OPC_LDI;
        out_dst_d    = ldi_dst_q;
        out_wr_d     = 1'b1;
        out_a_d      = '0;
        out_b_d      = DATA_W'(in_instr);
      end else begin
        out_opcode_d = opcode;
        out_dst_d    = ra;
        out_wr_d     = writes;
        out_a_d      = rd_data1;
        out_b_d      = rd_data2;
      end
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      ldi_dst_q    <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_dst_q    <= '0;
      out_wr_q     <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
    end else begin
      pend_q       <= pend_d;
      ldi_dst_q    <= ldi_dst_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_dst_q    <= out_dst_d;
      out_wr_q     <= out_wr_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_dst    = out_dst_q;
  assign out_wr     = out_wr_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the stage.
module tb_operand_fetch_stage;

  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_instr;
  logic [1:0]        rd_index1, rd_index2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              wb_valid;
  logic [1:0]        wb_index;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [1:0]        out_dst;
  logic              out_wr;
  logic [DATA_W-1:0] out_a, out_b;

  logic [DATA_W-1:0] rf [4];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state: the instruction sitting in ID/EX, outstanding writes, partial LDI.
  bit              m_valid;
  bit [3:0]        m_op;
  bit [1:0]        m_dst;
  bit              m_wr;
  bit [DATA_W-1:0] m_a, m_b;
  bit [3:0]        m_pend;
  bit              m_imm;
  bit [1:0]        m_ldi_dst;

  operand_fetch_stage #(.DATA_W(DATA_W), .OPC_LDI(4'h7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rd_index1 (rd_index1),
    .rd_index2 (rd_index2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .wb_valid  (wb_valid),
    .wb_index  (wb_index),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opcode(out_opcode),
    .out_dst   (out_dst),
    .out_wr    (out_wr),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  assign rd_data1 = rf[rd_index1];
  assign rd_data2 = rf[rd_index2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_a(input bit [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
  endfunction

  function automatic bit reads_b(input bit [3:0] op);
    return op inside {4'd1, 4'd2, 4'd5, 4'd6};
  endfunction

  function automatic bit writes_reg(input bit [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

  function automatic bit model_ready();
    bit [3:0] op;
    bit [1:0] a, b;
    op = in_instr[7:4];
    a  = in_instr[3:2];
    b  = in_instr[1:0];
    if (rst || flush) return 1'b0;
    if (m_valid && !out_ready) return 1'b0;
    if (m_imm) return 1'b1;
    if (reads_a(op) && m_pend[a]) return 1'b0;
    if (reads_b(op) && m_pend[b]) return 1'b0;
    if (writes_reg(op) && m_pend[a]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_dst = 0; m_wr = 0; m_a = 0; m_b = 0;
    m_pend = 0; m_imm = 0; m_ldi_dst = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit [3:0] set_v, clr_v;
    bit [3:0] op;
    bit       acc, free;
    if (rst) begin
      model_reset();
      return;
    end
    op    = in_instr[7:4];
    acc   = in_valid && model_ready();
    free  = !m_valid || out_ready;
    set_v = 0;
    clr_v = 0;
    if (wb_valid) clr_v[wb_index] = 1;
    if (flush) begin
      if (m_valid && m_wr && !out_ready) clr_v[m_dst] = 1;
      if (m_imm) clr_v[m_ldi_dst] = 1;
      m_valid = 0;
      m_imm   = 0;
    end else if (acc && m_imm) begin
      m_valid = 1; m_op = 4'd7; m_dst = m_ldi_dst; m_wr = 1;
      m_a = 0; m_b = {8'h00, in_instr};
      m_imm = 0;
    end else if (acc && op == 4'd7) begin
      m_imm = 1;
      m_ldi_dst = in_instr[3:2];
      set_v[in_instr[3:2]] = 1;
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_op = op; m_dst = in_instr[3:2]; m_wr = writes_reg(op);
      m_a = rf[in_instr[3:2]]; m_b = rf[in_instr[1:0]];
      if (writes_reg(op)) set_v[in_instr[3:2]] = 1;
    end else if (free) begin
      m_valid = 0;
    end
    m_pend = (m_pend & ~clr_v) | set_v;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_instr = 0; wb_valid = 0; wb_index = 0; flush = 0;
  endtask

  // Compare process: checks every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
      chk("rd_index1", {30'b0, rd_index1}, {30'b0, in_instr[3:2]});
      chk("rd_index2", {30'b0, rd_index2}, {30'b0, in_instr[1:0]});
      chk("pend", {28'b0, dut.pend_q}, {28'b0, m_pend});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("out_opcode", {28'b0, out_opcode}, {28'b0, m_op});
        chk("out_dst", {30'b0, out_dst}, {30'b0, m_dst});
        chk("out_wr", {31'b0, out_wr}, {31'b0, m_wr});
        chk("out_a", {16'b0, out_a}, {16'b0, m_a});
        chk("out_b", {16'b0, out_b}, {16'b0, m_b});
      end
    end
  end

  initial begin
    rst = 1; out_ready = 1;
    idle_inputs();
    rf[0] = 16'h1111; rf[1] = 16'h0005; rf[2] = 16'h0003; rf[3] = 16'h3333;
    model_reset();
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_a", {16'b0, out_a}, 32'd0);
    chk("rst_out_b", {16'b0, out_b}, 32'd0);
    chk("rst_pend", {28'b0, dut.pend_q}, 32'd0);
    rst = 0;
    cmp_en = 1;
    step();

    // ADD r1,r2
    in_valid = 1; in_instr = 8'h16; #1;
    chk("add_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_opcode", {28'b0, out_opcode}, 32'd1);
    chk("add_dst", {30'b0, out_dst}, 32'd1);
    chk("add_a", {16'b0, out_a}, 32'h0005);
    chk("add_b", {16'b0, out_b}, 32'h0003);
    chk("add_wr", {31'b0, out_wr}, 32'd1);
    chk("add_pend", {28'b0, dut.pend_q}, 32'b0010);
    wb_valid = 1; wb_index = 1; step(); wb_valid = 0;

    // ADD r1,r2 then SUB r2,r1: RAW on r1
    in_valid = 1; in_instr = 8'h16; step();
    in_instr = 8'h29; #1;
    chk("sub_held", {31'b0, in_ready}, 32'd0);
    step();
    wb_valid = 1; wb_index = 1; #1;
    chk("sub_held_wb", {31'b0, in_ready}, 32'd0);
    step();
    wb_valid = 0; #1;
    chk("sub_released", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    chk("sub_opcode", {28'b0, out_opcode}, 32'd2);
    wb_valid = 1; wb_index = 2; step(); wb_valid = 0;

    // LDI r3, 0xA5 into an empty slot with execute stalled
    out_ready = 0;
    in_valid = 1; in_instr = 8'h7C; step();
    in_instr = 8'hA5; step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ldi_valid", {31'b0, out_valid}, 32'd1);
      chk("ldi_dst", {30'b0, out_dst}, 32'd3);
      chk("ldi_a", {16'b0, out_a}, 32'd0);
      chk("ldi_b", {16'b0, out_b}, 32'h00A5);
      step();
    end
    out_ready = 1; step();
    chk("ldi_drained", {31'b0, out_valid}, 32'd0);
    wb_valid = 1; wb_index = 3; step(); wb_valid = 0;

    // LDI r2 then flush in the immediate phase
    in_valid = 1; in_instr = 8'h78; step();
    in_valid = 0; flush = 1; step();
    flush = 0;
    chk("ldiflush_pend", {28'b0, dut.pend_q}, 32'd0);
    chk("ldiflush_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1; in_instr = 8'h16; #1;
    chk("ldiflush_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    chk("ldiflush_decode", {28'b0, out_opcode}, 32'd1);
    wb_valid = 1; wb_index = 1; step(); wb_valid = 0;

    // ADD r0,r1 stalled then flushed; then flushed while being consumed
    out_ready = 0;
    in_valid = 1; in_instr = 8'h11; step();
    in_valid = 0; step();
    flush = 1; step();
    flush = 0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_pend", {28'b0, dut.pend_q}, 32'd0);
    in_valid = 1; in_instr = 8'h11; step();
    in_valid = 0; step();
    flush = 1; out_ready = 1; step();
    flush = 0;
    chk("flush_consumed_pend", {28'b0, dut.pend_q}, 32'b0001);
    wb_valid = 1; wb_index = 0; step(); wb_valid = 0;

    // Fill the scoreboard, then async reset mid-cycle
    for (int r = 0; r < 4; r++) begin
      in_valid = 1; in_instr = {4'h3, r[1:0], 2'b00}; step();
    end
    in_valid = 0;
    chk("full_pend", {28'b0, dut.pend_q}, 32'b1111);
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_pend", {28'b0, dut.pend_q}, 32'd0);
    step(); step();
    rst = 0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_index  = 2'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 3)] = 16'($urandom);
      step();
    end
    idle_inputs();
    step();
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
